// File: rtl/base_parity_scrub_pkg.sv
// Shared types for the background parity scrubber.
package base_parity_scrub_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    CHK   = 3'd3,
    GAP   = 3'd4,
    DRAIN = 3'd5
  } state_e;

endpackage

// File: rtl/base_parity_gen.sv
// Odd-parity generator per slice; bit 0 of each field is the MSB of the vector,
// and the last slice absorbs any remainder bits.
module base_parity_gen
  import base_parity_scrub_pkg::*;
#(
  parameter int dwidth = 64,
  parameter int pwidth = 8
) (
  input  logic [dwidth-1:0] data_i,
  output logic [pwidth-1:0] par_o
);

  localparam int wwidth = (dwidth + pwidth - 1) / pwidth;

  function automatic logic [pwidth-1:0] odd_parity(input logic [dwidth-1:0] d);
    logic [pwidth-1:0] acc;
    int s;
    acc = {pwidth{1'b1}};
    for (int j = 0; j < dwidth; j++) begin
      s = j / wwidth;
      if (s > pwidth - 1) begin
        s = pwidth - 1;
      end else begin
        s = s;
      end
      acc[pwidth-1-s] = acc[pwidth-1-s] ^ d[dwidth-1-j];
    end
    return acc;
  endfunction

  // Parity of the captured entry
  always_comb begin
    par_o = odd_parity(data_i);
  end

endmodule

// File: rtl/base_parity_scrub.sv
// Background scrubber: walks the array over a shared read port, re-checks
// stored parity and reports mismatches with a saturating count.
module base_parity_scrub
  import base_parity_scrub_pkg::*;
#(
  parameter int dwidth = 64,
  parameter int pwidth = 8,
  parameter int awidth = 10,
  parameter int depth  = 1024,
  parameter int cwidth = 16,
  parameter int gap    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_cont,
  input  logic              i_abort,
  output logic              o_rd_v,
  output logic [awidth-1:0] o_rd_addr,
  input  logic              i_rd_r,
  input  logic              i_rd_v,
  input  logic [dwidth-1:0] i_rd_d,
  input  logic [pwidth-1:0] i_rd_p,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_v,
  output logic [awidth-1:0] o_err_addr,
  output logic [pwidth-1:0] o_err_syn,
  output logic [cwidth-1:0] o_err_cnt,
  input  logic              i_err_clr
);

  localparam int GW = (gap > 1) ? $clog2(gap) : 1;
  localparam logic [GW-1:0]     GAP_LAST  = GW'((gap > 0) ? gap - 1 : 0);
  localparam logic [awidth-1:0] ADDR_LAST = awidth'(depth - 1);
  localparam logic [cwidth-1:0] CNT_ONE   = {{(cwidth-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [awidth-1:0] addr_q, addr_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [dwidth-1:0] dat_q;
  logic [pwidth-1:0] par_q, gen_s, syn_s;
  logic              rd_v_q, busy_q, done_q, err_v_q;
  logic [awidth-1:0] err_addr_q;
  logic [pwidth-1:0] err_syn_q;
  logic [cwidth-1:0] cnt_q, cnt_d;
  logic              chk_s, last_s, err_s, done_s;

  base_parity_gen #(.dwidth(dwidth), .pwidth(pwidth)) u_gen (
    .data_i (dat_q),
    .par_o  (gen_s)
  );

  // State register, capture and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      gcnt_q     <= '0;
      dat_q      <= '0;
      par_q      <= '0;
      rd_v_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_v_q    <= 1'b0;
      err_addr_q <= '0;
      err_syn_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      gcnt_q  <= gcnt_d;
      if (state_q == WAIT && i_rd_v) begin
        dat_q <= i_rd_d;
        par_q <= i_rd_p;
      end
      rd_v_q  <= (state_d == REQ);
      busy_q  <= (state_d != IDLE);
      done_q  <= done_s;
      err_v_q <= err_s;
      if (err_s) begin
        err_addr_q <= addr_q;
        err_syn_q  <= syn_s;
      end
      cnt_q <= cnt_d;
    end
  end

  // Next-state and address sequencing
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      IDLE: begin
        if (i_start && !i_abort) begin
          state_d = REQ;
          addr_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (i_abort)     state_d = IDLE;
        else if (i_rd_r) state_d = WAIT;
        else             state_d = REQ;
      end
      WAIT: begin
        // A return coinciding with abort is simply dropped; nothing left to drain.
        if (i_abort)     state_d = i_rd_v ? IDLE : DRAIN;
        else if (i_rd_v) state_d = CHK;
        else             state_d = WAIT;
      end
      CHK: begin
        gcnt_d = '0;
        if (last_s) addr_d = '0;
        else        addr_d = addr_q + 1'b1;
        if (i_abort || (last_s && !i_cont)) state_d = IDLE;
        else if (gap == 0)                  state_d = REQ;
        else                                state_d = GAP;
      end
      GAP: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (gcnt_q == GAP_LAST) begin
          state_d = REQ;
        end else begin
          state_d = GAP;
          gcnt_d  = gcnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (i_rd_v) state_d = IDLE;
        else        state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Check results and saturating error count
  always_comb begin
    chk_s  = (state_q == CHK);
    last_s = (addr_q == ADDR_LAST);
    syn_s  = gen_s ^ par_q;
    err_s  = chk_s && (syn_s != '0);
    done_s = chk_s && last_s && !i_cont && !i_abort;
    if (i_err_clr)                            cnt_d = err_s ? CNT_ONE : '0;
    else if (err_s && (cnt_q != {cwidth{1'b1}})) cnt_d = cnt_q + 1'b1;
    else                                      cnt_d = cnt_q;
  end

  assign o_rd_v     = rd_v_q;
  assign o_rd_addr  = addr_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err_v    = err_v_q;
  assign o_err_addr = err_addr_q;
  assign o_err_syn  = err_syn_q;
  assign o_err_cnt  = cnt_q;

endmodule

// File: tb/tb_base_parity_scrub.sv
// Self-checking bench for base_parity_scrub: the bench acts as the array,
// with a reference parity model and an expected-event scoreboard.
module tb_base_parity_scrub;

  localparam int DW = 16, PW = 2, AW = 2, DEPTH = 4, CW = 2, GAP = 2;

  logic          clk = 1'b0;
  logic          reset, i_start, i_cont, i_abort, i_rd_r, i_rd_v, i_err_clr;
  logic [DW-1:0] i_rd_d;
  logic [PW-1:0] i_rd_p;
  logic          o_rd_v, o_busy, o_done, o_err_v;
  logic [AW-1:0] o_rd_addr, o_err_addr;
  logic [PW-1:0] o_err_syn;
  logic [CW-1:0] o_err_cnt;

  base_parity_scrub #(.dwidth(DW), .pwidth(PW), .awidth(AW), .depth(DEPTH),
                      .cwidth(CW), .gap(GAP)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_cont(i_cont), .i_abort(i_abort),
    .o_rd_v(o_rd_v), .o_rd_addr(o_rd_addr), .i_rd_r(i_rd_r), .i_rd_v(i_rd_v),
    .i_rd_d(i_rd_d), .i_rd_p(i_rd_p), .o_busy(o_busy), .o_done(o_done),
    .o_err_v(o_err_v), .o_err_addr(o_err_addr), .o_err_syn(o_err_syn),
    .o_err_cnt(o_err_cnt), .i_err_clr(i_err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int a; int s; int c; } ev_t;
  ev_t got_err[$];
  ev_t exp_err[$];
  int  done_cyc[$];
  int  n_checks = 0, n_fail = 0;
  int  exp_cnt = 0;
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] mem_p [DEPTH];

  always @(negedge clk) begin
    if (o_err_v === 1'b1) got_err.push_back('{int'(o_err_addr), int'(o_err_syn), cyc});
    if (o_done === 1'b1) done_cyc.push_back(cyc);
  end

  // Odd parity per 8-bit slice, slice 0 being the upper byte
  function automatic logic [PW-1:0] ref_par(input logic [DW-1:0] d);
    logic [PW-1:0] p;
    p[1] = (($countones(d[15:8]) % 2) == 0);
    p[0] = (($countones(d[7:0]) % 2) == 0);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem();
    for (int a = 0; a < DEPTH; a++) begin
      mem_d[a] = 16'($urandom);
      mem_p[a] = ref_par(mem_d[a]);
    end
  endtask

  task automatic serve(input int stall, output int addr, output int req_c, output int ret_c);
    int n;
    logic [PW-1:0] syn;
    n = 0;
    while (o_rd_v !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(n < 50), 32'd1);
    addr  = int'(o_rd_addr);
    req_c = cyc;
    for (int k = 0; k < stall; k++) begin
      chk("stall_v", 32'(o_rd_v), 32'd1);
      chk("stall_addr", 32'(o_rd_addr), addr);
      @(negedge clk);
    end
    i_rd_r = 1'b1;
    @(negedge clk);
    i_rd_r = 1'b0;
    chk("req_drop", 32'(o_rd_v), 32'd0);
    i_rd_v = 1'b1;
    i_rd_d = mem_d[addr];
    i_rd_p = mem_p[addr];
    ret_c  = cyc;
    syn = mem_p[addr] ^ ref_par(mem_d[addr]);
    if (syn != '0) begin
      exp_err.push_back('{addr, int'(syn), ret_c + 2});
      exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
    end
    @(negedge clk);
    i_rd_v = 1'b0;
    i_rd_d = 16'($urandom);
    i_rd_p = 2'($urandom);
  endtask

  task automatic run_reads(input int stall_addr, input int first_k, output int last_ret);
    int a, rq, rt, prev;
    prev = -1;
    for (int k = first_k; k < DEPTH; k++) begin
      serve((k == stall_addr) ? 5 : 0, a, rq, rt);
      chk("pass_addr", a, k);
      if (prev >= 0) chk("gap_timing", rq - prev, 32'd4);
      prev = rt;
    end
    last_ret = prev;
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic check_errs(input string tag);
    chk({tag, "_nerr"}, got_err.size(), exp_err.size());
    for (int i = 0; i < exp_err.size() && i < got_err.size(); i++) begin
      chk({tag, "_eaddr"}, got_err[i].a, exp_err[i].a);
      chk({tag, "_esyn"},  got_err[i].s, exp_err[i].s);
      chk({tag, "_ecyc"},  got_err[i].c, exp_err[i].c);
    end
    got_err.delete();
    exp_err.delete();
  endtask

  task automatic check_done(input string tag, input int n, input int at);
    chk({tag, "_ndone"}, done_cyc.size(), n);
    if (n > 0) chk({tag, "_done_cyc"}, (done_cyc.size() > 0) ? done_cyc[0] : -1, at);
    done_cyc.delete();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_rdv"},  32'(o_rd_v), 32'd0);
    chk({tag, "_cnt"},  32'(o_err_cnt), exp_cnt);
  endtask

  initial begin
    int last_ret;
    logic [PW-1:0] flip;
    reset = 1'b1; i_start = 1'b0; i_cont = 1'b0; i_abort = 1'b0; i_rd_r = 1'b0;
    i_rd_v = 1'b0; i_rd_d = '0; i_rd_p = '0; i_err_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rdv", 32'(o_rd_v), 32'd0);
    chk("rst_addr", 32'(o_rd_addr), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_errv", 32'(o_err_v), 32'd0);
    chk("rst_eaddr", 32'(o_err_addr), 32'd0);
    chk("rst_esyn", 32'(o_err_syn), 32'd0);
    chk("rst_cnt", 32'(o_err_cnt), 32'd0);

    // Clean pass
    fill_mem();
    start_pulse();
    chk("t1_busy", 32'(o_busy), 32'd1);
    run_reads(-1, 0, last_ret);
    repeat (4) @(negedge clk);
    check_done("t1", 1, last_ret + 2);
    check_errs("t1");
    check_idle("t1");

    // Stored parity bit 0 flipped at address 2
    fill_mem();
    mem_p[2] = mem_p[2] ^ 2'b10;
    start_pulse();
    run_reads(-1, 0, last_ret);
    repeat (4) @(negedge clk);
    check_done("t2", 1, last_ret + 2);
    check_errs("t2");
    check_idle("t2");
    chk("t2_hold_addr", 32'(o_err_addr), 32'd2);
    chk("t2_hold_syn", 32'(o_err_syn), 32'd2);

    // Grant withheld for 5 cycles at address 1
    fill_mem();
    start_pulse();
    run_reads(1, 0, last_ret);
    repeat (4) @(negedge clk);
    check_done("t3", 1, last_ret + 2);
    check_errs("t3");
    check_idle("t3");

    // Abort while waiting, bad-parity return arrives 3 cycles later
    fill_mem();
    start_pulse();
    chk("t4_req", 32'(o_rd_v), 32'd1);
    i_rd_r = 1'b1;
    @(negedge clk);
    i_rd_r = 1'b0;
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("t4_busy1", 32'(o_busy), 32'd1);
    chk("t4_rdv1", 32'(o_rd_v), 32'd0);
    @(negedge clk);
    chk("t4_busy2", 32'(o_busy), 32'd1);
    @(negedge clk);
    chk("t4_busy3", 32'(o_busy), 32'd1);
    i_rd_v = 1'b1;
    i_rd_d = mem_d[0];
    i_rd_p = ~ref_par(mem_d[0]);
    @(negedge clk);
    i_rd_v = 1'b0;
    chk("t4_busy_drop", 32'(o_busy), 32'd0);
    repeat (4) @(negedge clk);
    check_done("t4", 0, 0);
    check_errs("t4");
    check_idle("t4");

    // Five errors over two chained passes, count saturates
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    chk("t5_clr", 32'(o_err_cnt), 32'd0);
    fill_mem();
    for (int a = 0; a < DEPTH; a++) begin
      flip = 2'($urandom_range(1, 3));
      if (a != 2) mem_p[a] = mem_p[a] ^ flip;
    end
    i_cont = 1'b1;
    start_pulse();
    run_reads(-1, 0, last_ret);
    fill_mem();
    mem_p[1] = mem_p[1] ^ 2'b01;
    mem_p[2] = mem_p[2] ^ 2'b11;
    run_reads(-1, 0, last_ret);
    repeat (4) @(negedge clk);
    check_done("t5", 0, 0);
    check_errs("t5");
    chk("t5_busy_cont", 32'(o_busy), 32'd1);
    fill_mem();
    i_cont = 1'b0;
    run_reads(-1, 0, last_ret);
    repeat (4) @(negedge clk);
    check_done("t5b", 1, last_ret + 2);
    check_errs("t5b");
    check_idle("t5b");
    chk("t5_sat", 32'(o_err_cnt), 32'd3);

    // Clear coinciding with a detected error leaves the count at one
    fill_mem();
    mem_p[0] = mem_p[0] ^ 2'b01;
    start_pulse();
    begin
      int a, rq, rt;
      serve(0, a, rq, rt);
      chk("t5c_addr", a, 32'd0);
      i_err_clr = 1'b1;
      exp_cnt = 1;
      @(negedge clk);
      i_err_clr = 1'b0;
      chk("t5c_errv", 32'(o_err_v), 32'd1);
      chk("t5c_cnt", 32'(o_err_cnt), 32'd1);
    end
    run_reads(-1, 1, last_ret);
    repeat (4) @(negedge clk);
    check_done("t5c", 1, last_ret + 2);
    check_errs("t5c");
    check_idle("t5c");

    // Reset while waiting, return arrives on the following cycle
    fill_mem();
    start_pulse();
    i_rd_r = 1'b1;
    @(negedge clk);
    i_rd_r = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;
    i_rd_v = 1'b1;
    i_rd_d = mem_d[0];
    i_rd_p = ~ref_par(mem_d[0]);
    @(negedge clk);
    i_rd_v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t6_rdv", 32'(o_rd_v), 32'd0);
      chk("t6_addr", 32'(o_rd_addr), 32'd0);
      chk("t6_busy", 32'(o_busy), 32'd0);
      chk("t6_errv", 32'(o_err_v), 32'd0);
      chk("t6_eaddr", 32'(o_err_addr), 32'd0);
      chk("t6_esyn", 32'(o_err_syn), 32'd0);
      chk("t6_cnt", 32'(o_err_cnt), 32'd0);
      @(negedge clk);
    end
    check_done("t6", 0, 0);
    check_errs("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
